// File: rtl/comfort_scheduler.sv
// Occupancy-gated heater/cooler/light scheduler with minimum-on and dead-time enforcement.
// Define COMFORT_SCHED_ECO_EN to make the HOLD phase count as unoccupied for load and light gating.
module comfort_scheduler #(
    parameter int HOLD_CYC = 16,
    parameter int MIN_ON   = 8,
    parameter int MIN_OFF  = 8,
    parameter int CTR_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motion_sen,
    input  logic       req_heat,
    input  logic       req_cool,
    input  logic       req_light,
    input  logic       power_ok,
    output logic       heater_en,
    output logic       cooler_en,
    output logic       light_en,
    output logic       occupied,
    output logic [1:0] load_state
);

    typedef enum logic [1:0] {
        VACANT   = 2'b00,
        OCCUPIED = 2'b01,
        HOLD     = 2'b10
    } occ_t;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        HEAT = 2'b01,
        COOL = 2'b10,
        DEAD = 2'b11
    } load_t;

    localparam logic [CTR_W-1:0] HOLD_LOAD = CTR_W'(HOLD_CYC - 1);
    localparam logic [CTR_W-1:0] ON_LIMIT  = CTR_W'(MIN_ON);
    localparam logic [CTR_W-1:0] OFF_LOAD  = CTR_W'(MIN_OFF - 1);
    localparam logic [CTR_W-1:0] CTR_ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_ZERO  = '0;

    occ_t             occ_q, occ_d;
    logic [CTR_W-1:0] hold_q, hold_d;
    load_t            load_q, load_d;
    logic [CTR_W-1:0] load_tmr_q, load_tmr_d;
    logic             light_q;

    logic occ_gate;
    logic eff_heat;
    logic eff_cool;
    logic grant_req;
    logic grant_ok;

    assign occupied = (occ_q == OCCUPIED) || (occ_q == HOLD);

`ifdef COMFORT_SCHED_ECO_EN
    assign occ_gate = (occ_q == OCCUPIED);
`else
    assign occ_gate = occupied;
`endif

    // Conflicting heat and cool requests cancel each other out.
    assign eff_heat = req_heat && !req_cool && occ_gate && power_ok;
    assign eff_cool = req_cool && !req_heat && occ_gate && power_ok;
    assign grant_ok = power_ok && occ_gate;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q  <= VACANT;
            hold_q <= CTR_ZERO;
        end else begin
            occ_q  <= occ_d;
            hold_q <= hold_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        hold_d = hold_q;
        unique case (occ_q)
            VACANT: begin
                if (motion_sen) begin
                    occ_d = OCCUPIED;
                end
            end
            OCCUPIED: begin
                if (!motion_sen) begin
                    occ_d  = HOLD;
                    hold_d = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (motion_sen) begin
                    occ_d = OCCUPIED;
                end else if (hold_q == CTR_ZERO) begin
                    occ_d = VACANT;
                end else begin
                    hold_d = hold_q - CTR_ONE;
                end
            end
            default: begin
                occ_d  = VACANT;
                hold_d = CTR_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q     <= OFF;
            load_tmr_q <= CTR_ZERO;
        end else begin
            load_q     <= load_d;
            load_tmr_q <= load_tmr_d;
        end
    end

    // A grant survives a dropped request until MIN_ON, but never a loss of power or occupancy.
    always_comb begin
        load_d     = load_q;
        load_tmr_d = load_tmr_q;
        grant_req  = 1'b0;
        unique case (load_q)
            OFF: begin
                if (eff_heat) begin
                    load_d     = HEAT;
                    load_tmr_d = CTR_ZERO;
                end else if (eff_cool) begin
                    load_d     = COOL;
                    load_tmr_d = CTR_ZERO;
                end
            end
            HEAT, COOL: begin
                grant_req = (load_q == HEAT) ? eff_heat : eff_cool;
                if (!grant_ok) begin
                    load_d     = DEAD;
                    load_tmr_d = OFF_LOAD;
                end else if (!grant_req && (load_tmr_q == ON_LIMIT)) begin
                    load_d     = DEAD;
                    load_tmr_d = OFF_LOAD;
                end else if (load_tmr_q != ON_LIMIT) begin
                    load_tmr_d = load_tmr_q + CTR_ONE;
                end
            end
            DEAD: begin
                if (load_tmr_q == CTR_ZERO) begin
                    load_d = OFF;
                end else begin
                    load_tmr_d = load_tmr_q - CTR_ONE;
                end
            end
            default: begin
                load_d     = OFF;
                load_tmr_d = CTR_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            light_q <= 1'b0;
        end else begin
            light_q <= req_light && occ_gate;
        end
    end

    assign light_en   = light_q;
    assign heater_en  = (load_q == HEAT);
    assign cooler_en  = (load_q == COOL);
    assign load_state = load_q;

    // The only way between heating and cooling runs through DEAD.
    assert property (@(posedge clk) disable iff (!reset) (load_q == HEAT) |=> (load_q != COOL));
    assert property (@(posedge clk) disable iff (!reset) (load_q == COOL) |=> (load_q != HEAT));
    assert property (@(posedge clk) !(heater_en && cooler_en));

endmodule
